// File: rtl/hack_data_memory.sv
// Hack CPU data-port responder: RAM/SCREEN/KBD decode, combinational reads, clocked writes,
// and a screen-write mirror FIFO streaming to the framebuffer over valid/ready.
module hack_data_memory #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic        key_strobe,
    input  logic [15:0] key_code,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic [12:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        fb_overflow,
    output logic        bus_error
);
    localparam int MEM_WORDS = 24576;

    logic [15:0] mem [0:MEM_WORDS-1];
    logic [12:0] fifo_addr [0:FIFO_DEPTH-1];
    logic [15:0] fifo_data [0:FIFO_DEPTH-1];

    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   count;
    logic [15:0]        kbd_reg;

    logic is_mem, is_kbd, is_unmapped, is_screen;
    logic push_req, push_ok, pop, fifo_full;

    assign is_mem      = addressM < 15'h6000;
    assign is_kbd      = addressM == 15'h6000;
    assign is_unmapped = addressM > 15'h6000;
    assign is_screen   = addressM[14:13] == 2'b10;

    assign fifo_full = count == (FIFO_AW+1)'(FIFO_DEPTH);
    assign fb_valid  = count != '0;
    assign pop       = fb_valid && fb_ready;
    assign push_req  = writeM && is_screen;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
    assign push_ok   = push_req && (!fifo_full || pop);

    assign fb_addr = fifo_addr[rd_ptr];
    assign fb_data = fifo_data[rd_ptr];

    always_comb begin
        inM = 16'h0000;
        if (is_mem)
            inM = mem[addressM];
        else if (is_kbd)
            inM = kbd_reg;
    end

    // Storage arrays are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (writeM && is_mem)
            mem[addressM] <= outM;
        if (push_ok) begin
            fifo_addr[wr_ptr] <= addressM[12:0];
            fifo_data[wr_ptr] <= outM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            kbd_reg     <= 16'h0000;
            fb_overflow <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok)
                fb_overflow <= 1'b1;
            if (is_unmapped)
                bus_error <= 1'b1;
            if (key_strobe)
                kbd_reg <= key_code;
        end
    end
endmodule
